// File: rtl/ram_arb_pkg.sv
// Shared encodings and default widths for the two-port RAM arbiter.
// Used by the arbiter core and by the top-level RAM steering logic.
package ram_arb_pkg;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_gnt_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin, or port-1 priority bounded by a burst counter.
// gnt is one-hot or zero, and is forced to zero while rst is high.
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter int FIXED_PRI = 0,
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    last_gnt_t        last_gnt_reg, last_gnt_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic             burst_full;

    assign burst_full = (burst_cnt_reg == BURST_MAX);

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    if (FIXED_PRI != 0) begin
                        gnt = burst_full ? 2'b01 : 2'b10;
                    end else begin
                        gnt = (last_gnt_reg == LAST1) ? 2'b01 : 2'b10;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    // Counter tracks how long port 0 has been kept waiting; saturates at BURST_MAX.
    always_comb begin
        last_gnt_next  = last_gnt_reg;
        burst_cnt_next = burst_cnt_reg;
        if (gnt[0]) begin
            last_gnt_next = LAST0;
        end else if (gnt[1]) begin
            last_gnt_next = LAST1;
        end
        if (!req[0] || gnt[0]) begin
            burst_cnt_next = '0;
        end else if (gnt[1] && !burst_full) begin
            burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg  <= LAST1;
            burst_cnt_reg <= '0;
        end else begin
            last_gnt_reg  <= last_gnt_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters and routes
// read data back to the winning port one cycle after its grant.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int FIXED_PRI = 0,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic              m0_wena,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_wena,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_ena,
    output logic              wena,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    logic [1:0] gnt;
    logic       rsp_pend_reg, rsp_pend_next;
    logic       rsp_id_reg, rsp_id_next;
    logic       rsp_live;

    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI),
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1_valid, m0_valid}),
        .gnt (gnt)
    );

    assign m0_ready = gnt[0];
    assign m1_ready = gnt[1];
    assign ram_ena  = gnt[0] | gnt[1];

    always_comb begin
        wena    = 1'b0;
        addr    = '0;
        data_in = '0;
        if (gnt[0]) begin
            wena    = m0_wena;
            addr    = m0_addr;
            data_in = m0_wdata;
        end else if (gnt[1]) begin
            wena    = m1_wena;
            addr    = m1_addr;
            data_in = m1_wdata;
        end
    end

    assign rsp_pend_next = ram_ena & ~wena;
    assign rsp_id_next   = gnt[1] ? PORT1 : PORT0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend_reg <= 1'b0;
            rsp_id_reg   <= PORT0;
        end else begin
            rsp_pend_reg <= rsp_pend_next;
            rsp_id_reg   <= rsp_id_next;
        end
    end

    // A response registered just before reset is suppressed while rst is high.
    assign rsp_live  = rsp_pend_reg & ~rst;
    assign m0_rvalid = rsp_live & (rsp_id_reg == PORT0);
    assign m1_rvalid = rsp_live & (rsp_id_reg == PORT1);
    assign m0_rdata  = m0_rvalid ? data_out : '0;
    assign m1_rdata  = m1_rvalid ? data_out : '0;

endmodule
